// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared move codes, FSM state encodings and default grid dimensions
package grid_pkg;

    localparam int DEF_GRID_W      = 20;
    localparam int DEF_GRID_H      = 15;
    localparam int DEF_NUM_MAPS    = 4;
    localparam int DEF_NUM_PLAYERS = 2;

    // Any code not listed here is treated as NONE.
    localparam logic [2:0] MOVE_UP    = 3'b001;
    localparam logic [2:0] MOVE_LEFT  = 3'b010;
    localparam logic [2:0] MOVE_DOWN  = 3'b011;
    localparam logic [2:0] MOVE_RIGHT = 3'b100;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE   = 2'd0;
    localparam fsm_state_t ST_LOOKUP = 2'd1;
    localparam fsm_state_t ST_COMMIT = 2'd2;

endpackage

// File: rtl/grid_mover_if.sv
// rtl/grid_mover_if.sv - move request / response handshake bundle
interface grid_mover_if #(
    parameter int PW = 1,
    parameter int XW = 5,
    parameter int YW = 4
);

    logic          req_valid;
    logic          req_ready;
    logic [PW-1:0] req_player;
    logic [2:0]    req_move;

    logic          rsp_valid;
    logic [PW-1:0] rsp_player;
    logic          rsp_blocked;
    logic [XW-1:0] rsp_x;
    logic [YW-1:0] rsp_y;

    modport master (
        output req_valid, req_player, req_move,
        input  req_ready, rsp_valid, rsp_player, rsp_blocked, rsp_x, rsp_y
    );

    modport slave (
        input  req_valid, req_player, req_move,
        output req_ready, rsp_valid, rsp_player, rsp_blocked, rsp_x, rsp_y
    );

endinterface

// File: rtl/map_ram.sv
// rtl/map_ram.sv - wall map storage, one write port and one synchronous read port
module map_ram
    import grid_pkg::*;
#(
    parameter int  GRID_W   = DEF_GRID_W,
    parameter int  GRID_H   = DEF_GRID_H,
    parameter int  NUM_MAPS = DEF_NUM_MAPS,
    localparam int MW       = $clog2(NUM_MAPS),
    localparam int YW       = $clog2(GRID_H)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [MW-1:0]     wr_map,
    input  logic [YW-1:0]     wr_row,
    input  logic [GRID_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [MW-1:0]     rd_map,
    input  logic [YW-1:0]     rd_row,
    output logic [GRID_W-1:0] rd_data
);

    localparam int DEPTH = NUM_MAPS * GRID_H;
    localparam int AW    = $clog2(DEPTH);

    logic [GRID_W-1:0] mem [DEPTH];
    logic [GRID_W-1:0] rd_data_q;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              wr_ok;
    logic              rd_ok;

    // Map/row to linear address; rows past GRID_H or maps past NUM_MAPS never touch the array.
    always_comb begin
        wr_addr = AW'(wr_map) * AW'(GRID_H) + AW'(wr_row);
        rd_addr = AW'(rd_map) * AW'(GRID_H) + AW'(rd_row);
        wr_ok   = wr_en && (int'(wr_row) < GRID_H) && (int'(wr_map) < NUM_MAPS);
        rd_ok   = rd_en && (int'(rd_row) < GRID_H) && (int'(rd_map) < NUM_MAPS);
    end

    // Unreset storage; a same-cycle read of the row being written sees the old contents.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_ok) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/grid_mover.sv
// rtl/grid_mover.sv - tile-grid move resolver with wall maps and player occupancy
module grid_mover
    import grid_pkg::*;
#(
    parameter int  GRID_W      = DEF_GRID_W,
    parameter int  GRID_H      = DEF_GRID_H,
    parameter int  NUM_MAPS    = DEF_NUM_MAPS,
    parameter int  NUM_PLAYERS = DEF_NUM_PLAYERS,
    localparam int XW          = $clog2(GRID_W),
    localparam int YW          = $clog2(GRID_H),
    localparam int MW          = $clog2(NUM_MAPS),
    localparam int PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MW-1:0]             map_sel,
    input  logic                      wr_en,
    input  logic [MW-1:0]             wr_map,
    input  logic [YW-1:0]             wr_row,
    input  logic [GRID_W-1:0]         wr_data,
    grid_mover_if.slave               bus,
    output logic [NUM_PLAYERS*XW-1:0] pos_x,
    output logic [NUM_PLAYERS*YW-1:0] pos_y
);

    fsm_state_t state_q, state_d;
    logic [PW-1:0] player_q, player_d;
    logic [MW-1:0] map_q, map_d;
    logic          none_q, none_d;
    logic          pre_blk_q, pre_blk_d;
    logic [XW-1:0] tgt_x_q, tgt_x_d;
    logic [YW-1:0] tgt_y_q, tgt_y_d;
    logic [XW-1:0] old_x_q, old_x_d;
    logic [YW-1:0] old_y_q, old_y_d;

    logic          rsp_valid_q, rsp_valid_d;
    logic [PW-1:0] rsp_player_q, rsp_player_d;
    logic          rsp_blocked_q, rsp_blocked_d;
    logic [XW-1:0] rsp_x_q, rsp_x_d;
    logic [YW-1:0] rsp_y_q, rsp_y_d;

    logic [XW-1:0] pos_x_q [NUM_PLAYERS];
    logic [XW-1:0] pos_x_d [NUM_PLAYERS];
    logic [YW-1:0] pos_y_q [NUM_PLAYERS];
    logic [YW-1:0] pos_y_d [NUM_PLAYERS];

    logic [XW-1:0]     cur_x, nx;
    logic [YW-1:0]     cur_y, ny;
    logic              player_ok;
    logic              edge_blk;
    logic              is_none;
    logic              occupied;
    logic              wall_hit;
    logic              blocked;
    logic              rd_en;
    logic [GRID_W-1:0] rd_data;

    // Wall row for the target is fetched only when the target is inside the grid and a real move.
    assign rd_en = (state_q == ST_LOOKUP) && !pre_blk_q && !none_q;

    map_ram #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .NUM_MAPS (NUM_MAPS)
    ) u_map_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_map  (wr_map),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_map  (map_q),
        .rd_row  (tgt_y_q),
        .rd_data (rd_data)
    );

    // Current position of the requesting player; an out-of-range index selects nothing.
    always_comb begin
        cur_x     = '0;
        cur_y     = '0;
        player_ok = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (bus.req_player == PW'(p)) begin
                cur_x     = pos_x_q[p];
                cur_y     = pos_y_q[p];
                player_ok = 1'b1;
            end
        end
    end

    // Target tile of the request; edge moves fall back to the current tile so no wrapped row is read.
    always_comb begin
        nx       = cur_x;
        ny       = cur_y;
        edge_blk = 1'b0;
        is_none  = 1'b0;
        case (bus.req_move)
            MOVE_RIGHT: begin
                edge_blk = (cur_x == XW'(GRID_W - 1));
                nx       = cur_x + XW'(1);
            end
            MOVE_LEFT: begin
                edge_blk = (cur_x == '0);
                nx       = cur_x - XW'(1);
            end
            MOVE_UP: begin
                edge_blk = (cur_y == '0);
                ny       = cur_y - YW'(1);
            end
            MOVE_DOWN: begin
                edge_blk = (cur_y == YW'(GRID_H - 1));
                ny       = cur_y + YW'(1);
            end
            default: is_none = 1'b1;
        endcase
        if (edge_blk) begin
            nx = cur_x;
            ny = cur_y;
        end
    end

    // Collision verdict in COMMIT: wall bit from the fetched row or another player on the target.
    always_comb begin
        wall_hit = rd_data[tgt_x_q];
        occupied = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if ((player_q != PW'(p)) && (pos_x_q[p] == tgt_x_q) && (pos_y_q[p] == tgt_y_q)) begin
                occupied = 1'b1;
            end
        end
        blocked = pre_blk_q || (!none_q && (wall_hit || occupied));
    end

    // Request FSM: capture at acceptance, read in LOOKUP, respond and move in COMMIT.
    always_comb begin
        state_d       = state_q;
        player_d      = player_q;
        map_d         = map_q;
        none_d        = none_q;
        pre_blk_d     = pre_blk_q;
        tgt_x_d       = tgt_x_q;
        tgt_y_d       = tgt_y_q;
        old_x_d       = old_x_q;
        old_y_d       = old_y_q;
        rsp_valid_d   = 1'b0;
        rsp_player_d  = rsp_player_q;
        rsp_blocked_d = rsp_blocked_q;
        rsp_x_d       = rsp_x_q;
        rsp_y_d       = rsp_y_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d   = ST_LOOKUP;
                    player_d  = bus.req_player;
                    map_d     = map_sel;
                    none_d    = is_none;
                    pre_blk_d = edge_blk || !player_ok;
                    tgt_x_d   = nx;
                    tgt_y_d   = ny;
                    old_x_d   = cur_x;
                    old_y_d   = cur_y;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d       = ST_IDLE;
                rsp_valid_d   = 1'b1;
                rsp_player_d  = player_q;
                rsp_blocked_d = blocked;
                if (blocked || none_q) begin
                    rsp_x_d = old_x_q;
                    rsp_y_d = old_y_q;
                end else begin
                    rsp_x_d = tgt_x_q;
                    rsp_y_d = tgt_y_q;
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if (player_q == PW'(p)) begin
                            pos_x_d[p] = tgt_x_q;
                            pos_y_d[p] = tgt_y_q;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any request in flight and restores start positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            player_q      <= '0;
            map_q         <= '0;
            none_q        <= 1'b0;
            pre_blk_q     <= 1'b0;
            tgt_x_q       <= '0;
            tgt_y_q       <= '0;
            old_x_q       <= '0;
            old_y_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_player_q  <= '0;
            rsp_blocked_q <= 1'b0;
            rsp_x_q       <= '0;
            rsp_y_q       <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                pos_x_q[p] <= XW'(1 + p);
                pos_y_q[p] <= YW'(1);
            end
        end else begin
            state_q       <= state_d;
            player_q      <= player_d;
            map_q         <= map_d;
            none_q        <= none_d;
            pre_blk_q     <= pre_blk_d;
            tgt_x_q       <= tgt_x_d;
            tgt_y_q       <= tgt_y_d;
            old_x_q       <= old_x_d;
            old_y_q       <= old_y_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_player_q  <= rsp_player_d;
            rsp_blocked_q <= rsp_blocked_d;
            rsp_x_q       <= rsp_x_d;
            rsp_y_q       <= rsp_y_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
        end
    end

    // Flatten positions for the outside world, player p in slice p.
    always_comb begin
        pos_x = '0;
        pos_y = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            pos_x[p*XW +: XW] = pos_x_q[p];
            pos_y[p*YW +: YW] = pos_y_q[p];
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_player  = rsp_player_q;
    assign bus.rsp_blocked = rsp_blocked_q;
    assign bus.rsp_x       = rsp_x_q;
    assign bus.rsp_y       = rsp_y_q;

endmodule
